// File: rtl/alu_issue_pkg.sv
// Shared types and constants for the ALU issue controller.
// Holds opcode/funct values, ALU select codes, FSM states and field positions.
package alu_issue_pkg;

    // Instruction field bit positions
    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;
    localparam int FN_MSB  = 5;
    localparam int FN_LSB  = 0;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    // R-type funct codes
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_NOT = 6'h28;
    localparam logic [5:0] FN_SLT = 6'h2A;
    localparam logic [5:0] FN_SGT = 6'h2B;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_AND    = 4'd2,
        ALU_OR     = 4'd3,
        ALU_XOR    = 4'd4,
        ALU_NOR    = 4'd5,
        ALU_NOT_A  = 4'd6,
        ALU_SLT    = 4'd7,
        ALU_SGT    = 4'd8,
        ALU_LUI    = 4'd9,
        ALU_PASS_A = 4'd10,
        ALU_PASS_B = 4'd11
    } alu_sel_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_e;

    typedef enum logic {
        DEST_RD = 1'b0,
        DEST_RT = 1'b1
    } dest_sel_e;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational instruction decoder for the ALU issue controller.
// Ports: instr in; alu_sel, imm_sext, use_imm, dest_sel, legal out.
module alu_issue_decode
    import alu_issue_pkg::*;
(
    input  logic [31:0] instr,
    output alu_sel_e    alu_sel,
    output logic        imm_sext,
    output logic        use_imm,
    output dest_sel_e   dest_sel,
    output logic        legal
);

    logic [5:0] op;
    logic [5:0] fn;
    logic       unused_fields;

    assign op = instr[OP_MSB:OP_LSB];
    assign fn = instr[FN_MSB:FN_LSB];

    // Register and immediate fields are consumed by the top level
    assign unused_fields = ^instr[RS_MSB:FN_MSB+1];

    always_comb begin
        alu_sel  = ALU_ADD;
        imm_sext = 1'b0;
        use_imm  = 1'b1;
        dest_sel = DEST_RT;
        legal    = 1'b1;
        unique case (1'b1)
            (op == OP_RTYPE): begin
                use_imm  = 1'b0;
                dest_sel = DEST_RD;
                unique case (1'b1)
                    (fn == FN_ADD): alu_sel = ALU_ADD;
                    (fn == FN_SUB): alu_sel = ALU_SUB;
                    (fn == FN_AND): alu_sel = ALU_AND;
                    (fn == FN_OR):  alu_sel = ALU_OR;
                    (fn == FN_XOR): alu_sel = ALU_XOR;
                    (fn == FN_NOR): alu_sel = ALU_NOR;
                    (fn == FN_NOT): alu_sel = ALU_NOT_A;
                    (fn == FN_SLT): alu_sel = ALU_SLT;
                    (fn == FN_SGT): alu_sel = ALU_SGT;
                    default:        legal   = 1'b0;
                endcase
            end
            (op == OP_ADDI): imm_sext = 1'b1;
            (op == OP_SLTI): begin
                alu_sel  = ALU_SLT;
                imm_sext = 1'b1;
            end
            (op == OP_ANDI): alu_sel = ALU_AND;
            (op == OP_ORI):  alu_sel = ALU_OR;
            (op == OP_XORI): alu_sel = ALU_XOR;
            (op == OP_LUI):  alu_sel = ALU_LUI;
            default:         legal   = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Decode/issue controller: accepts an instruction, drives the ALU, offers write-back.
// Ports: in_valid/in_ready/instr/rs_data/rt_data in, alu_sel/a/b + alu_res to ALU,
// wb_valid/wb_ready/wb_addr/wb_data out, illegal pulse. Macro ALU_ISSUE_PERF_CNT_EN
// adds issued_cnt and illegal_cnt outputs.
module alu_issue_ctrl
    import alu_issue_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic [3:0]       alu_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_res,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [4:0]       wb_addr,
    output logic [WIDTH-1:0] wb_data,
    output logic             illegal
`ifdef ALU_ISSUE_PERF_CNT_EN
    ,
    output logic [31:0]      issued_cnt,
    output logic [15:0]      illegal_cnt
`endif
);

    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    state_e           state_q, state_d;
    alu_sel_e         sel_q, sel_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [4:0]       addr_q, addr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]    lat_q, lat_d;
    logic             wbv_q, wbv_d;
    logic             ill_q, ill_d;

    alu_sel_e         dec_sel;
    logic             dec_sext;
    logic             dec_imm;
    dest_sel_e        dec_dest;
    logic             dec_legal;

    logic [15:0]      imm;
    logic [WIDTH-1:0] imm_z;
    logic [WIDTH-1:0] imm_s;
    logic [WIDTH-1:0] imm_b;

    alu_issue_decode u_dec (
        .instr    (instr),
        .alu_sel  (dec_sel),
        .imm_sext (dec_sext),
        .use_imm  (dec_imm),
        .dest_sel (dec_dest),
        .legal    (dec_legal)
    );

    assign imm   = instr[IMM_MSB:IMM_LSB];
    assign imm_z = {{(WIDTH-16){1'b0}}, imm};
    assign imm_s = {{(WIDTH-16){imm[15]}}, imm};
    assign imm_b = dec_sext ? imm_s : imm_z;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        a_d     = a_q;
        b_d     = b_q;
        addr_d  = addr_q;
        data_d  = data_q;
        lat_d   = lat_q;
        wbv_d   = 1'b0;
        ill_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid && dec_legal) begin
                    sel_d   = dec_sel;
                    a_d     = rs_data;
                    b_d     = dec_imm ? imm_b : rt_data;
                    // LUI shifts the raw immediate in operand A
                    if (dec_sel == ALU_LUI) begin
                        a_d = imm_z;
                        b_d = '0;
                    end
                    addr_d  = (dec_dest == DEST_RD) ?
                              instr[RD_MSB:RD_LSB] :
                              instr[RT_MSB:RT_LSB];
                    lat_d   = CW'(ALU_LAT - 1);
                    state_d = S_EXEC;
                end else if (in_valid) begin
                    ill_d = 1'b1;
                end
            end
            S_EXEC: begin
                if (lat_q != '0) begin
                    lat_d = lat_q - 1'b1;
                end else begin
                    data_d  = alu_res;
                    // Writes to r0 are dropped without a handshake
                    state_d = (addr_q != 5'd0) ? S_WB : S_IDLE;
                end
            end
            S_WB: begin
                // wb_valid is registered, so it rises one cycle into WB
                if (wbv_q && wb_ready) begin
                    state_d = S_IDLE;
                end else begin
                    wbv_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sel_q   <= ALU_ADD;
            a_q     <= '0;
            b_q     <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            lat_q   <= '0;
            wbv_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            a_q     <= a_d;
            b_q     <= b_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            lat_q   <= lat_d;
            wbv_q   <= wbv_d;
            ill_q   <= ill_d;
        end
    end

    assign in_ready = (state_q == S_IDLE);
    assign alu_sel  = sel_q;
    assign alu_a    = a_q;
    assign alu_b    = b_q;
    assign wb_valid = wbv_q;
    assign wb_addr  = addr_q;
    assign wb_data  = data_q;
    assign illegal  = ill_q;

`ifdef ALU_ISSUE_PERF_CNT_EN
    logic [31:0] iss_q, iss_d;
    logic [15:0] ilc_q, ilc_d;

    always_comb begin
        iss_d = iss_q;
        ilc_d = ilc_q;
        if (state_q == S_IDLE && in_valid && dec_legal) begin
            iss_d = iss_q + 32'd1;
        end
        if (ill_d) begin
            ilc_d = ilc_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            iss_q <= '0;
            ilc_q <= '0;
        end else begin
            iss_q <= iss_d;
            ilc_q <= ilc_d;
        end
    end

    assign issued_cnt  = iss_q;
    assign illegal_cnt = ilc_q;
`else
    // No event counters in this build
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU model.
// Instances: u_dut (ALU_LAT=1) and u_dut4 (ALU_LAT=4).
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst4 = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_valid4 = 1'b0;
    logic [31:0] instr = '0;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic        wb_ready = 1'b1;

    logic        in_ready, in_ready4;
    logic [3:0]  alu_sel, alu_sel4;
    logic [31:0] alu_a, alu_a4, alu_b, alu_b4;
    logic [31:0] alu_res, alu_res4;
    logic        wb_valid, wb_valid4;
    logic [4:0]  wb_addr, wb_addr4;
    logic [31:0] wb_data, wb_data4;
    logic        illegal, illegal4;
`ifdef ALU_ISSUE_PERF_CNT_EN
    logic [31:0] issued_cnt, issued_cnt4;
    logic [15:0] illegal_cnt, illegal_cnt4;
`endif

    int checks = 0;
    int passed = 0;
    int wbv_cyc = 0;
    int wbv4_cyc = 0;
    int wb_hs = 0;
    int n;
    int base;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_model(
        input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
        case (s)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ~(a | b);
            4'd6:  return ~a;
            4'd7:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd8:  return ($signed(a) > $signed(b)) ? 32'd1 : 32'd0;
            4'd9:  return a << 16;
            4'd10: return a;
            4'd11: return b;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    assign alu_res  = alu_model(alu_sel, alu_a, alu_b);
    assign alu_res4 = alu_model(alu_sel4, alu_a4, alu_b4);

    always @(posedge clk) begin
        if (wb_valid) wbv_cyc++;
        if (wb_valid4) wbv4_cyc++;
        if (wb_valid && wb_ready) wb_hs++;
    end

    alu_issue_ctrl #(.WIDTH(32), .ALU_LAT(1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
        .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_res(alu_res),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr),
        .wb_data(wb_data), .illegal(illegal)
`ifdef ALU_ISSUE_PERF_CNT_EN
        , .issued_cnt(issued_cnt), .illegal_cnt(illegal_cnt)
`endif
    );

    alu_issue_ctrl #(.WIDTH(32), .ALU_LAT(4)) u_dut4 (
        .clk(clk), .rst(rst4), .in_valid(in_valid4), .in_ready(in_ready4),
        .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
        .alu_sel(alu_sel4), .alu_a(alu_a4), .alu_b(alu_b4), .alu_res(alu_res4),
        .wb_valid(wb_valid4), .wb_ready(wb_ready), .wb_addr(wb_addr4),
        .wb_data(wb_data4), .illegal(illegal4)
`ifdef ALU_ISSUE_PERF_CNT_EN
        , .issued_cnt(issued_cnt4), .illegal_cnt(illegal_cnt4)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] rtype(input logic [5:0] fn,
        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op,
        input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic issue(input logic [31:0] ins, input logic [31:0] a,
                         input logic [31:0] b);
        instr = ins; rs_data = a; rt_data = b; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic issue4(input logic [31:0] ins, input logic [31:0] a,
                          input logic [31:0] b);
        instr = ins; rs_data = a; rt_data = b; in_valid4 = 1'b1;
        @(negedge clk);
        in_valid4 = 1'b0;
    endtask

    // Counts negedges until wb_valid, bounded
    task automatic wait_wbv(output int cnt);
        cnt = 0;
        while (!wb_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_outs", {alu_sel, alu_a, alu_b}, 0);
        chk("rst_wb", {wb_valid, wb_addr, wb_data, illegal}, 0);
        rst = 1'b0;
        rst4 = 1'b0;

        // Test 1: ADD rd=3, 5+7
        wb_ready = 1'b1;
        issue(rtype(6'h20, 5'd1, 5'd2, 5'd3), 32'd5, 32'd7);
        chk("t1_ops", {alu_sel, alu_a, alu_b}, {4'd0, 32'd5, 32'd7});
        chk("t1_busy", in_ready, 0);
        wait_wbv(n);
        chk("t1_lat", n, 2);
        chk("t1_wb", {wb_addr, wb_data}, {5'd3, 32'd12});
        @(negedge clk);
        chk("t1_done", {wb_valid, in_ready}, 2'b01);

        // Test 2: ADDI with negative immediate
        issue(itype(6'h08, 5'd1, 5'd4, 16'hFFFF), 32'd10, 32'd0);
        chk("t2_b", alu_b, 32'hFFFF_FFFF);
        wait_wbv(n);
        chk("t2_wb", {wb_addr, wb_data}, {5'd4, 32'd9});
        @(negedge clk);

        // Test 3: ORI zero-extends
        issue(itype(6'h0D, 5'd1, 5'd5, 16'hFFFF), 32'h1234_0000, 32'd0);
        chk("t3_ops", {alu_sel, alu_b}, {4'd3, 32'h0000_FFFF});
        wait_wbv(n);
        chk("t3_wb", wb_data, 32'h1234_FFFF);
        @(negedge clk);

        // Test 4: LUI
        issue(itype(6'h0F, 5'd0, 5'd6, 16'h1234), 32'hFFFF_FFFF, 32'd0);
        chk("t4_ops", {alu_sel, alu_a, alu_b}, {4'd9, 32'h1234, 32'd0});
        wait_wbv(n);
        chk("t4_wb", {wb_addr, wb_data}, {5'd6, 32'h1234_0000});
        @(negedge clk);

        // Test 5: write-back back-pressure
        wb_ready = 1'b0;
        issue(rtype(6'h22, 5'd1, 5'd2, 5'd7), 32'd20, 32'd5);
        wait_wbv(n);
        chk("t5_lat", n, 2);
        base = wb_hs;
        for (int i = 0; i < 5; i++) begin
            chk("t5_hold", {wb_valid, wb_addr, wb_data, in_ready},
                {1'b1, 5'd7, 32'd15, 1'b0});
            @(negedge clk);
        end
        wb_ready = 1'b1;
        @(negedge clk);
        chk("t5_one_hs", wb_hs - base, 1);
        chk("t5_done", {wb_valid, in_ready}, 2'b01);

        // Test 6: illegal opcode, illegal funct, then SLT to r0
        base = wbv_cyc;
        issue(itype(6'h3F, 5'd1, 5'd2, 16'h0), 32'd0, 32'd0);
        chk("t6_ill_hi", {illegal, in_ready, wb_valid}, 3'b110);
        @(negedge clk);
        chk("t6_ill_lo", illegal, 0);
        issue(rtype(6'h21, 5'd1, 5'd2, 5'd3), 32'd0, 32'd0);
        chk("t6_fn_ill", {illegal, in_ready}, 2'b11);
        issue(rtype(6'h2A, 5'd1, 5'd2, 5'd0), 32'hFFFF_FFFD, 32'd2);
        chk("t6_slt_sel", {alu_sel, illegal, in_ready}, {4'd7, 2'b00});
        @(negedge clk);
        chk("t6_slt_idle", in_ready, 1);
        repeat (4) @(negedge clk);
        chk("t6_no_wb", wbv_cyc - base, 0);

        // Test 7: ALU_LAT=4 latency, then reset in EXEC
        issue4(rtype(6'h20, 5'd1, 5'd2, 5'd2), 32'd1, 32'd1);
        n = 0;
        while (!wb_valid4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t7_lat4", n, 5);
        chk("t7_wb4", {wb_addr4, wb_data4}, {5'd2, 32'd2});
        @(negedge clk);
        chk("t7_hs4", {wb_valid4, in_ready4}, 2'b01);
        base = wbv4_cyc;
        issue4(rtype(6'h26, 5'd1, 5'd2, 5'd9), 32'hF0, 32'h0F);
        chk("t7_exec", {in_ready4, alu_sel4}, {1'b0, 4'd4});
        @(negedge clk);
        rst4 = 1'b1;
        @(negedge clk);
        rst4 = 1'b0;
        chk("t7_rst_ops", {alu_sel4, alu_a4, alu_b4}, 0);
        chk("t7_rst_wb", {wb_valid4, wb_addr4, wb_data4, illegal4}, 0);
        chk("t7_rst_rdy", in_ready4, 1);
        repeat (8) @(negedge clk);
        chk("t7_no_wb", wbv4_cyc - base, 0);

`ifdef ALU_ISSUE_PERF_CNT_EN
        // Test 8: event counters
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t8_rst", {issued_cnt, illegal_cnt}, 0);
        for (int i = 0; i < 3; i++) begin
            issue(rtype(6'h20, 5'd1, 5'd2, 5'd0), i, 32'd1);
            @(negedge clk);
        end
        issue(itype(6'h3F, 5'd0, 5'd0, 16'h0), 32'd0, 32'd0);
        issue(rtype(6'h3F, 5'd0, 5'd0, 5'd1), 32'd0, 32'd0);
        @(negedge clk);
        chk("t8_issued", issued_cnt, 3);
        chk("t8_illegal", illegal_cnt, 2);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
